// File: rtl/cf_sram_1024x32_if.sv
// rtl/cf_sram_1024x32_if.sv - data/address bus bundle for the 1024x32 SRAM macro
interface cf_sram_1024x32_if #(
  parameter int AW = 10,
  parameter int DW = 32
) ();
  logic [DW-1:0] DO;
  logic [DW-1:0] DI;
  logic [AW-1:0] AD;
  logic          EN;
  logic          R_WB;
  logic [DW-1:0] BEN;

  modport master (
    output DI, AD, EN, R_WB, BEN,
    input  DO
  );

  modport slave (
    input  DI, AD, EN, R_WB, BEN,
    output DO
  );
endinterface

// File: rtl/cf_sram_1024x32.sv
// rtl/cf_sram_1024x32.sv - single-port 1024x32 synchronous SRAM with bit mask, power gating and scan
module cf_sram_1024x32 #(
  parameter int AW    = 10,
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic              CLKin,
  input  logic              RSTn,
  cf_sram_1024x32_if.slave  bus,
  input  logic              TM,
  input  logic              SM,
  input  logic              WLBI,
  input  logic              WLOFF,
  input  logic              ScanInCC,
  input  logic              ScanInDL,
  input  logic              ScanInDR,
  output logic              ScanOutCC,
  input  logic              vpwrac,
  input  logic              vpwrpc
);

  localparam int CW = AW + 2;
  localparam int HW = DW / 2;

  logic [DW-1:0] mem [DEPTH];

  logic [DW-1:0] do_q, do_d;
  logic [CW-1:0] ctrl_q, ctrl_d;

  logic pwr_ok;
  logic acc;
  logic rd;
  logic wr;

  // Burn-in only stresses wordlines on silicon; it has no logical effect.
  wire unused_wlbi = WLBI;

  assign pwr_ok = vpwrac & vpwrpc;
  assign acc    = bus.EN & pwr_ok & ~SM & ~WLOFF;
  assign rd     = acc & bus.R_WB;
  assign wr     = acc & ~bus.R_WB;

  always_ff @(posedge CLKin) begin
    if (wr) begin
      mem[bus.AD] <= (mem[bus.AD] & ~bus.BEN) | (bus.DI & bus.BEN);
    end
  end

  always_comb begin
    do_d   = do_q;
    ctrl_d = ctrl_q;
    if (SM) begin
      ctrl_d = {ctrl_q[CW-2:0], ScanInCC};
    end
    // Power loss dominates scan and reads so DO never shows stale data.
    if (!pwr_ok) begin
      do_d = '0;
    end else if (SM) begin
      do_d = {do_q[DW-2:HW], ScanInDL, do_q[HW-2:0], ScanInDR};
    end else if (rd) begin
      do_d = TM ? bus.DI : mem[bus.AD];
    end
  end

  always_ff @(posedge CLKin or negedge RSTn) begin
    if (!RSTn) begin
      do_q   <= '0;
      ctrl_q <= '0;
    end else begin
      do_q   <= do_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.DO    = do_q;
  assign ScanOutCC = ctrl_q[CW-1];

endmodule

// File: tb/tb_cf_sram_1024x32.sv
// tb/tb_cf_sram_1024x32.sv - scoreboard bench for the 1024x32 SRAM macro
module tb_cf_sram_1024x32;

  logic clk;
  logic rst_n;
  logic TM, SM, WLBI, WLOFF;
  logic ScanInCC, ScanInDL, ScanInDR;
  logic ScanOutCC;
  logic vpwrac, vpwrpc;

  cf_sram_1024x32_if bus ();

  cf_sram_1024x32 dut (
    .CLKin    (clk),
    .RSTn     (rst_n),
    .bus      (bus),
    .TM       (TM),
    .SM       (SM),
    .WLBI     (WLBI),
    .WLOFF    (WLOFF),
    .ScanInCC (ScanInCC),
    .ScanInDL (ScanInDL),
    .ScanInDR (ScanInDR),
    .ScanOutCC(ScanOutCC),
    .vpwrac   (vpwrac),
    .vpwrpc   (vpwrpc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic        soc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_mem [1024];
  bit          m_written [1024];
  logic [31:0] m_do;
  bit          cc_q[$];

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (bus.DO !== e.d || ScanOutCC !== e.soc) begin
        miscompares++;
        $display("FAIL %s: DO=%h ScanOutCC=%b, expected DO=%h ScanOutCC=%b",
                 e.name, bus.DO, ScanOutCC, e.d, e.soc);
      end
    end
  end

  always @(negedge rst_n) begin
    #1;
    vectors++;
    if (bus.DO !== 32'h0 || ScanOutCC !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: DO=%h ScanOutCC=%b, expected DO=00000000 ScanOutCC=0",
               bus.DO, ScanOutCC);
    end
  end

  task automatic cc_clear();
    cc_q.delete();
    for (int i = 0; i < 12; i++) cc_q.push_back(1'b0);
  endtask

  // Advance one clock edge, predicting its effect from the datasheet rules.
  task automatic step(input string nm);
    bit pwr, acc;
    pwr = vpwrac && vpwrpc;
    acc = bus.EN && pwr && !SM && !WLOFF;
    if (!rst_n) begin
      m_do = 32'h0;
      cc_clear();
    end else begin
      if (SM) begin
        cc_q.push_back(ScanInCC);
        void'(cc_q.pop_front());
      end
      if (!pwr)
        m_do = 32'h0;
      else if (SM)
        m_do = {m_do[30:16], ScanInDL, m_do[14:0], ScanInDR};
      else if (acc && bus.R_WB)
        m_do = TM ? bus.DI : m_mem[bus.AD];
      if (acc && !bus.R_WB) begin
        m_mem[bus.AD] = (m_mem[bus.AD] & ~bus.BEN) | (bus.DI & bus.BEN);
        if (bus.BEN == 32'hFFFF_FFFF) m_written[bus.AD] = 1'b1;
      end
    end
    exp_q.push_back('{cyc + 1, m_do, cc_q[0], nm});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.EN = 1'b0; bus.R_WB = 1'b1; TM = 1'b0; SM = 1'b0; WLOFF = 1'b0;
    WLBI = 1'b0; ScanInCC = 1'b0; ScanInDL = 1'b0; ScanInDR = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d,
                    input logic [31:0] ben, input string nm);
    bus.EN = 1'b1; bus.R_WB = 1'b0; bus.AD = a; bus.DI = d; bus.BEN = ben;
    step(nm);
    idle_bus();
  endtask

  task automatic rd(input logic [9:0] a, input string nm);
    bus.EN = 1'b1; bus.R_WB = 1'b1; bus.AD = a; bus.DI = $urandom;
    step(nm);
    idle_bus();
  endtask

  int pool [12] = '{0, 1, 2, 5, 7, 100, 255, 511, 512, 768, 1022, 1023};

  initial begin
    rst_n = 1'b0;
    vpwrac = 1'b1; vpwrpc = 1'b1;
    bus.AD = '0; bus.DI = '0; bus.BEN = '0;
    idle_bus();
    m_do = 32'h0;
    cc_clear();
    for (int i = 0; i < 1024; i++) begin m_mem[i] = 32'h0; m_written[i] = 1'b0; end

    @(posedge clk); #1;
    step("reset0");
    step("reset1");
    rst_n = 1'b1;
    step("post_reset");

    wr(10'd5, 32'hDEADBEEF, 32'hFFFF_FFFF, "wr5");
    rd(10'd5, "rd5");
    wr(10'd100, 32'h12345678, 32'hFFFF_FFFF, "wr100_hold");
    rd(10'd100, "rd100");
    rd(10'd5, "rd5_persist");
    wr(10'd0, 32'h0BAD_F00D, 32'hFFFF_FFFF, "wr0");
    wr(10'd1023, 32'h8765_4321, 32'hFFFF_FFFF, "wr1023");
    rd(10'd0, "rd0");
    rd(10'd1023, "rd1023");
    wr(10'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "wr7_ones");
    wr(10'd7, 32'h0000_0000, 32'h0000_FFFF, "wr7_mask");
    rd(10'd7, "rd7_mask");

    bus.EN = 1'b0; bus.R_WB = 1'b0; bus.AD = 10'd5; bus.DI = 32'hCAFEF00D; bus.BEN = '1;
    step("en0_write");
    rd(10'd5, "rd5_after_en0");

    WLOFF = 1'b1; bus.EN = 1'b1; bus.R_WB = 1'b0; bus.AD = 10'd5; bus.DI = 32'hCAFEF00D; bus.BEN = '1;
    step("wloff_write");
    idle_bus();
    rd(10'd5, "rd5_after_wloff");

    vpwrpc = 1'b0;
    bus.EN = 1'b1; bus.R_WB = 1'b0; bus.AD = 10'd5; bus.DI = 32'hCAFEF00D; bus.BEN = '1;
    step("pwr_low_write");
    idle_bus();
    step("pwr_low_idle");
    vpwrpc = 1'b1;
    rd(10'd5, "rd5_after_pwr");

    TM = 1'b1;
    bus.EN = 1'b1; bus.R_WB = 1'b1; bus.AD = 10'd5; bus.DI = 32'hA5A5A5A5;
    step("tm_bypass");
    idle_bus();
    rd(10'd5, "rd5_after_tm");

    SM = 1'b1; bus.EN = 1'b1; bus.R_WB = 1'b0; bus.AD = 10'd5; bus.DI = 32'h0; bus.BEN = '1;
    for (int i = 0; i < 13; i++) begin
      ScanInCC = (i == 0);
      ScanInDL = $urandom_range(0, 1);
      ScanInDR = $urandom_range(0, 1);
      step($sformatf("scan_shift%0d", i));
    end
    for (int i = 0; i < 5; i++) begin
      ScanInCC = 1'b1;
      ScanInDL = $urandom_range(0, 1);
      ScanInDR = $urandom_range(0, 1);
      step($sformatf("scan_pre_rst%0d", i));
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    step("scan_in_reset");
    rst_n = 1'b1;
    idle_bus();
    step("post_scan_reset");
    rd(10'd5, "rd5_after_scan");

    for (int n = 0; n < 300; n++) begin
      int a, r;
      a = pool[$urandom_range(0, 11)];
      r = $urandom_range(0, 9);
      if (!m_written[a]) begin
        wr(a[9:0], $urandom, 32'hFFFF_FFFF, "rnd_init_wr");
      end else if (r <= 3) begin
        wr(a[9:0], $urandom, $urandom, "rnd_mask_wr");
      end else if (r <= 6) begin
        rd(a[9:0], "rnd_rd");
      end else if (r == 7) begin
        TM = 1'b1; bus.EN = 1'b1; bus.R_WB = 1'b1; bus.AD = a[9:0]; bus.DI = $urandom;
        step("rnd_tm_rd");
        idle_bus();
      end else if (r == 8) begin
        bus.EN = $urandom_range(0, 1); WLOFF = ~bus.EN; WLBI = $urandom_range(0, 1);
        bus.R_WB = $urandom_range(0, 1); bus.AD = a[9:0]; bus.DI = $urandom; bus.BEN = $urandom;
        step("rnd_blocked");
        idle_bus();
      end else begin
        SM = 1'b1; bus.EN = 1'b1; bus.R_WB = $urandom_range(0, 1); bus.AD = a[9:0];
        bus.DI = $urandom; bus.BEN = '1;
        ScanInCC = $urandom_range(0, 1); ScanInDL = $urandom_range(0, 1); ScanInDR = $urandom_range(0, 1);
        step("rnd_scan");
        idle_bus();
      end
    end

    step("drain");
    @(negedge clk); #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cf_sram_1024x32.md
Name: cf_sram_1024x32

Overview:
Synthesizable behavioural model of the 1024-word x 32-bit single-port synchronous SRAM macro used as on-chip data/instruction storage. One address port serves both read and write, selected by R_WB. There is a per-bit write mask, a registered read output, power-good gating, and a simple scan/test interface that is inert in functional mode.

Parameters:
AW, 10, address width
DW, 32, data width
DEPTH, 1024, number of words (2**AW)

Ports:
CLKin  in  1  clock; all array/register activity on rising edge
RSTn  in  1  asynchronous active-low reset
DO  out  DW  registered read data
DI  in  DW  write data
AD  in  AW  word address
EN  in  1  access enable; no access when 0
R_WB  in  1  1 = read, 0 = write
BEN  in  DW  bit write enable; 1 = bit written
TM  in  1  test mode: read bypass
SM  in  1  scan mode
WLBI  in  1  wordline burn-in; no functional effect
WLOFF  in  1  wordline off; blocks all array access
ScanInCC  in  1  control scan chain serial input
ScanInDL  in  1  DO[31:16] scan chain serial input
ScanInDR  in  1  DO[15:0] scan chain serial input
ScanOutCC  out  1  control scan chain serial output
vpwrac  in  1  array power good, active-high
vpwrpc  in  1  periphery power good, active-high

Behaviour:
- Reset (RSTn=0, async): DO=0, control scan register=0, ScanOutCC=0. Array contents are not cleared. Deassertion is sampled synchronously to CLKin.
- Power gate: pwr_ok = vpwrac & vpwrpc.
  - pwr_ok=0: no array access and DO is held at 0.
  - Array contents are retained while vpwrac=1.
- Access qualifier: acc = EN & pwr_ok & ~SM & ~WLOFF.
- Write (acc, R_WB=0, rising edge):
  - mem[AD] = (mem[AD] & ~BEN) | (DI & BEN).
  - BEN=all-ones writes the full word; BEN=0 leaves the word unchanged.
  - DO holds its previous value during a write.
- Read (acc, R_WB=1, rising edge): DO <= mem[AD].
  - Latency is 1 cycle; data is valid after the edge that samples the request.
  - DO holds its value until the next read, reset, or power loss.
- TM=1 during a read: DO <= DI (bypass) instead of the array. Writes are unaffected by TM.
- EN=0: array and DO unchanged, whatever the other inputs.
- WLOFF=1: same as EN=0.
- WLBI: ignored functionally.
- Address: the full 10-bit range 0..1023 is valid. No wrap or aliasing.
- Scan (SM=1): array access is suppressed. Each rising edge:
  - The 12-bit control register {R_WB, EN, AD} shifts left with ScanInCC entering the LSB. ScanOutCC = register MSB.
  - DO[31:16] shifts left with ScanInDL entering bit 16.
  - DO[15:0] shifts left with ScanInDR entering bit 0.
- SM=0: the control register is not updated and ScanOutCC holds its value.
- Uninitialised words read 0 in simulation (array zero-initialised at time 0 for the model).

Test Plan:
- Reset with power good, then release: DO=0. Write 0xDEADBEEF to addr 5 (EN=1, R_WB=0, BEN=all-ones), then read addr 5 -> DO=0xDEADBEEF one edge after the read request.
- Write 0x12345678 to addr 100, read 100 -> 0x12345678. Re-read 5 -> 0xDEADBEEF (persistence, no aliasing). Addr 0 and 1023 write/read OK.
- Write 0xFFFFFFFF to addr 7, then write 0x00000000 with BEN=0x0000FFFF -> read 0xFFFF0000.
- Three separate disabled-write checks on addr 5, each followed by a read expecting 0xDEADBEEF:
  - EN=0 with write data 0xCAFEF00D.
  - WLOFF=1 during the write.
  - vpwrpc=0 during the write; DO must be 0 while power is low.
- TM=1 read with DI=0xA5A5A5A5 -> DO=0xA5A5A5A5; array unchanged.
- SM=1: shift ScanInCC with pattern 1 followed by 12 zeros -> ScanOutCC=1 after 12 edges. No array change. Assert RSTn=0 mid-shift -> DO=0 and ScanOutCC=0 immediately.
